// File: rtl/deser_pkg.sv
// Shared definitions for the serial frame receiver: default word width
// and the receiver FSM state encoding.
package deser_pkg;

  // Default number of data bits per frame.
  localparam int DEFAULT_WIDTH = 8;

  // Receiver states; the numeric encoding is fixed so other blocks and
  // debug tools can decode a captured state value.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry first-in first-out word buffer between the frame receiver and
// the parallel consumer. The full flag already accounts for a pop in the
// same cycle, so a full FIFO being drained can still accept a push.
module word_fifo2
  import deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             C,
  input  logic             R,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  logic             w_pop;
  logic             w_push;

  // A pop only takes effect when a word is present; a push only when
  // there is room (after counting the same-cycle pop).
  assign w_pop  = pop & (r_count != 2'd0);
  assign full   = (r_count == 2'd2) & ~w_pop;
  assign w_push = push & ~full;

  assign valid  = (r_count != 2'd0);
  assign dout   = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy; the head entry is never overwritten
  // unless it is being popped in the same cycle.
  always_ff @(posedge C) begin
    if (R) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/deserializer_rx.sv
// Serial-to-parallel frame receiver. Collects WIDTH data bits (LSB first,
// first bit flagged by S_START) plus one even-parity bit, and queues good
// words in a two-entry FIFO. Parity failures and drops due to a full FIFO
// are reported as one-cycle pulses.
module deserializer_rx
  import deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             C,
  input  logic             R,
  input  logic             S_VALID,
  input  logic             S_DATA,
  input  logic             S_START,
  output logic [WIDTH-1:0] P_DATA,
  output logic             P_VALID,
  input  logic             P_READY,
  output logic             PAR_ERR,
  output logic             OVERFLOW
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_par;
  logic             r_par_err;
  logic             r_overflow;

  logic [WIDTH:0]   w_cat;
  logic [WIDTH-1:0] w_shift_next;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_par_good;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  // New bits enter at the top and move down, so after WIDTH bits the
  // first (LSB) bit sits at position 0.
  assign w_cat        = {S_DATA, r_shift};
  assign w_shift_next = w_cat[WIDTH:1];
  assign w_cnt_inc    = r_cnt + CW'(1);

  // Running XOR of the data bits combined with the incoming parity bit.
  assign w_par_good   = ~(r_par ^ S_DATA);

  // A parity bit that is not itself a new frame start completes the frame.
  assign w_push = (r_state == ST_PARITY) & S_VALID & ~S_START
                & w_par_good & ~w_full;
  assign w_pop  = P_VALID & P_READY;

  assign PAR_ERR  = r_par_err;
  assign OVERFLOW = r_overflow;

  // Receiver FSM: only qualified bits advance it; S_START restarts a frame
  // from any state, silently dropping whatever was in progress.
  always_ff @(posedge C) begin
    if (R) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_par_err  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_par_err  <= 1'b0;
      r_overflow <= 1'b0;
      if (S_VALID) begin
        if (S_START) begin
          r_state <= (WIDTH == 1) ? ST_PARITY : ST_SHIFT;
          r_cnt   <= CW'(1);
          r_shift <= w_shift_next;
          r_par   <= S_DATA;
        end else begin
          case (r_state)
            ST_IDLE: begin
              // Stray bits outside a frame are ignored.
            end
            ST_SHIFT: begin
              r_shift <= w_shift_next;
              r_par   <= r_par ^ S_DATA;
              r_cnt   <= w_cnt_inc;
              if (w_cnt_inc == CW'(WIDTH)) begin
                r_state <= ST_PARITY;
              end
            end
            ST_PARITY: begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              if (!w_par_good) begin
                r_par_err <= 1'b1;
              end else if (w_full) begin
                r_overflow <= 1'b1;
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end
          endcase
        end
      end
    end
  end

  word_fifo2 #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .C     (C),
    .R     (R),
    .push  (w_push),
    .din   (r_shift),
    .full  (w_full),
    .pop   (w_pop),
    .dout  (P_DATA),
    .valid (P_VALID)
  );

endmodule

// File: tb/tb_deserializer_rx.sv
// Directed bench for deserializer_rx: reset state, good/bad parity, FIFO
// overflow and ordering, same-cycle pop while full, long gaps, frame abort
// by S_START and reset in mid-frame.
module tb_deserializer_rx;

  logic       C;
  logic       R;
  logic       S_VALID;
  logic       S_DATA;
  logic       S_START;
  logic [7:0] P_DATA;
  logic       P_VALID;
  logic       P_READY;
  logic       PAR_ERR;
  logic       OVERFLOW;

  int checks;
  int errors;
  int n_deliv;
  int n_perr;
  int n_ovf;
  logic [7:0] last_word;

  deserializer_rx #(.WIDTH(8)) dut (
    .C        (C),
    .R        (R),
    .S_VALID  (S_VALID),
    .S_DATA   (S_DATA),
    .S_START  (S_START),
    .P_DATA   (P_DATA),
    .P_VALID  (P_VALID),
    .P_READY  (P_READY),
    .PAR_ERR  (PAR_ERR),
    .OVERFLOW (OVERFLOW)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // Event counters observed at each rising edge.
  always @(posedge C) begin
    if (!R) begin
      if (P_VALID && P_READY) begin
        n_deliv   = n_deliv + 1;
        last_word = P_DATA;
      end
      if (PAR_ERR)  n_perr = n_perr + 1;
      if (OVERFLOW) n_ovf  = n_ovf + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge C);
    #1;
  endtask

  // One qualified serial bit, then 'gap' idle cycles; returns 1 ns after an edge.
  task automatic send_bit(input logic st, input logic d, input int gap);
    @(negedge C);
    S_VALID = 1'b1;
    S_START = st;
    S_DATA  = d;
    @(posedge C);
    #1;
    S_VALID = 1'b0;
    S_START = 1'b0;
    S_DATA  = 1'b0;
    if (gap > 0) idle(gap);
  endtask

  task automatic send_data_bits(input logic [7:0] data, input int gap);
    for (int i = 0; i < 8; i++) send_bit(i == 0, data[i], gap);
  endtask

  // Full frame; bad_par flips the parity bit.
  task automatic send_frame(input logic [7:0] data, input logic bad_par, input int gap);
    send_data_bits(data, gap);
    send_bit(1'b0, (^data) ^ bad_par, 0);
  endtask

  initial begin
    logic [7:0] w;
    int d0;
    int p0;
    int o0;
    checks = 0; errors = 0; n_deliv = 0; n_perr = 0; n_ovf = 0; last_word = 8'h00;
    R = 1'b1; S_VALID = 1'b0; S_DATA = 1'b0; S_START = 1'b0; P_READY = 1'b1;

    // Reset state
    idle(3);
    check("rst_pvalid", P_VALID, 0);
    check("rst_pdata", P_DATA, 0);
    check("rst_parerr", PAR_ERR, 0);
    check("rst_ovf", OVERFLOW, 0);
    @(negedge C); R = 1'b0;
    idle(2);

    // Good frame 0xA5: word appears one cycle after the parity bit, for one cycle
    send_frame(8'hA5, 1'b0, 0);
    check("a5_valid", P_VALID, 1);
    check("a5_data", P_DATA, 8'hA5);
    check("a5_noerr", PAR_ERR, 0);
    idle(1);
    check("a5_drained", P_VALID, 0);
    check("a5_count", n_deliv, 1);

    // Same frame with wrong parity
    send_frame(8'hA5, 1'b1, 0);
    check("bad_perr", PAR_ERR, 1);
    check("bad_valid", P_VALID, 0);
    idle(1);
    check("bad_perr_end", PAR_ERR, 0);
    check("bad_valid2", P_VALID, 0);

    // Overflow: consumer stalled, three good frames
    P_READY = 1'b0;
    send_frame(8'h01, 1'b0, 0);
    send_frame(8'h02, 1'b0, 0);
    check("ovf_hold", P_DATA, 8'h01);
    check("ovf_none_yet", OVERFLOW, 0);
    send_frame(8'h03, 1'b0, 0);
    check("ovf_pulse", OVERFLOW, 1);
    check("ovf_head", P_DATA, 8'h01);
    idle(1);
    check("ovf_pulse_end", OVERFLOW, 0);
    check("ovf_stable", P_DATA, 8'h01);
    P_READY = 1'b1;
    idle(1);
    check("ovf_second", P_DATA, 8'h02);
    check("ovf_second_v", P_VALID, 1);
    idle(1);
    check("ovf_empty", P_VALID, 0);
    check("ovf_last", last_word, 8'h02);
    check("ovf_once", n_ovf, 1);

    // Full FIFO popped in the same cycle as the parity bit accepts the word
    P_READY = 1'b0;
    send_frame(8'h11, 1'b0, 0);
    send_frame(8'h22, 1'b0, 0);
    w = 8'h33;
    send_data_bits(w, 0);
    @(negedge C);
    S_VALID = 1'b1; S_START = 1'b0; S_DATA = ^w; P_READY = 1'b1;
    @(posedge C);
    #1;
    S_VALID = 1'b0; S_DATA = 1'b0; P_READY = 1'b0;
    check("popfull_ovf", OVERFLOW, 0);
    check("popfull_head", P_DATA, 8'h22);
    P_READY = 1'b1;
    idle(1);
    check("popfull_next", P_DATA, 8'h33);
    check("popfull_nv", P_VALID, 1);
    idle(1);
    check("popfull_empty", P_VALID, 0);
    check("popfull_ovfcnt", n_ovf, 1);

    // Long gaps between bits
    d0 = n_deliv; p0 = n_perr; o0 = n_ovf;
    send_frame(8'h3C, 1'b0, 5);
    check("gap_valid", P_VALID, 1);
    check("gap_data", P_DATA, 8'h3C);
    idle(1);
    check("gap_count", n_deliv, d0 + 1);
    check("gap_noperr", n_perr, p0);
    check("gap_noovf", n_ovf, o0);

    // Restart after 4 bits, then a full 0x7E frame
    d0 = n_deliv; p0 = n_perr;
    for (int i = 0; i < 4; i++) send_bit(i == 0, 1'b1, 0);
    send_frame(8'h7E, 1'b0, 0);
    check("abort_data", P_DATA, 8'h7E);
    idle(2);
    check("abort_count", n_deliv, d0 + 1);
    check("abort_last", last_word, 8'h7E);
    check("abort_noperr", n_perr, p0);

    // Reset mid-frame while a word is queued, then tail bits without S_START
    P_READY = 1'b0;
    send_frame(8'h99, 1'b0, 0);
    check("prerst_valid", P_VALID, 1);
    w = 8'h5A;
    for (int i = 0; i < 4; i++) send_bit(i == 0, w[i], 0);
    @(negedge C); R = 1'b1;
    @(posedge C); #1;
    check("midrst_valid", P_VALID, 0);
    check("midrst_data", P_DATA, 0);
    @(negedge C); R = 1'b0;
    P_READY = 1'b1;
    d0 = n_deliv; p0 = n_perr; o0 = n_ovf;
    for (int i = 4; i < 8; i++) send_bit(1'b0, w[i], 0);
    send_bit(1'b0, ^w, 0);
    send_bit(1'b0, 1'b1, 0);
    idle(3);
    check("midrst_nodeliv", n_deliv, d0);
    check("midrst_noperr", n_perr, p0);
    check("midrst_noovf", n_ovf, o0);

    // Recovery: a clean frame after the reset
    send_frame(8'h42, 1'b0, 1);
    check("recover_data", P_DATA, 8'h42);
    idle(1);
    check("recover_count", n_deliv, d0 + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deserializer_rx.md
DESERIALIZER_RX -- requirements
Module: deserializer_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of data bits per frame.
REQ-002 The block SHALL have port C, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port R, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port S_VALID, input, 1 bit: the serial bit on S_DATA is valid this cycle.
REQ-005 The block SHALL have port S_DATA, input, 1 bit: the serial data bit.
REQ-006 The block SHALL have port S_START, input, 1 bit: qualified by S_VALID, marks the first data bit of a frame.
REQ-007 The block SHALL have port P_DATA, output, WIDTH bits: the assembled word at the FIFO head.
REQ-008 The block SHALL have port P_VALID, output, 1 bit: P_DATA holds a valid word.
REQ-009 The block SHALL have port P_READY, input, 1 bit: the consumer accepts the word when P_VALID and P_READY are both high.
REQ-010 The block SHALL have port PAR_ERR, output, 1 bit: one-cycle pulse when a frame fails its parity check.
REQ-011 The block SHALL have port OVERFLOW, output, 1 bit: one-cycle pulse when a good frame is dropped because the FIFO is full.

Function
REQ-012 The frame format SHALL be: WIDTH data bits LSB first, the first one flagged by S_START, followed by one even-parity bit (XOR of the data bits and the parity bit equals 0).
REQ-013 Only cycles with S_VALID=1 SHALL advance the receiver; with S_VALID=0 all receiver state SHALL hold, so gaps of any length are allowed.
REQ-014 The FSM SHALL have states IDLE, SHIFT and PARITY.
- IDLE -> SHIFT on S_VALID&S_START, capturing bit 0 and setting the bit counter to 1.
- SHIFT -> PARITY when the bit counter reaches WIDTH.
- PARITY -> IDLE on the next S_VALID.
REQ-015 In IDLE, S_VALID bits with S_START=0 SHALL be ignored.
REQ-016 S_VALID&S_START received in SHIFT or PARITY SHALL abort the current frame (no word, no error pulse) and start a new frame with that bit as bit 0.
REQ-017 On the parity bit: if parity is good and the FIFO is not full, the word SHALL be pushed; if parity is bad, the word SHALL be discarded and PAR_ERR SHALL pulse in the following cycle.
REQ-018 On good parity with a full FIFO, the word SHALL be discarded and OVERFLOW SHALL pulse in the following cycle.
REQ-019 The FIFO status used for REQ-017/018 SHALL include a pop occurring in the same cycle, so a full FIFO being popped in that cycle accepts the push.
REQ-020 Latency: P_VALID SHALL rise in the cycle after the parity bit is sampled when the FIFO was empty.
REQ-021 The output FIFO SHALL hold 2 words in first-in, first-out order.
REQ-022 P_DATA SHALL stay stable while P_VALID=1 and P_READY=0.
REQ-023 A simultaneous push and pop SHALL keep the occupancy unchanged.
REQ-024 The bit counter SHALL be clog2(WIDTH+1) bits wide and SHALL never wrap; it is cleared on entry to IDLE.

Reset
REQ-025 While R=1 at a rising edge of C, the FSM SHALL enter IDLE, the counter and FIFO SHALL be cleared, and P_VALID=0, P_DATA=0, PAR_ERR=0, OVERFLOW=0.
REQ-026 A reset in the middle of a frame SHALL discard the partial frame, and the following bits SHALL be ignored until the next S_START.
REQ-027 R SHALL have priority over all other inputs.

Structure
REQ-028 The FSM state encoding (IDLE=0, SHIFT=1, PARITY=2) and the default WIDTH SHALL reside in shared package deser_pkg.
REQ-029 The 2-entry FIFO SHALL be a separate sub-module word_fifo2 (ports C, R, push, din, full, pop, dout, valid).
REQ-030 All flops SHALL be plain positive-edge flops with reset logic in the D path, and the design SHALL map to the team's DFF/NAND/NOR/NOT cell set without asynchronous set or reset.

Verification
REQ-031 Frame 0xA5 (bits 1,0,1,0,0,1,0,1, parity 0), P_READY=1 -> P_VALID high for 1 cycle, one cycle after the parity bit, with P_DATA=0xA5.
REQ-032 Same frame with parity 1 -> PAR_ERR pulses for 1 cycle; P_VALID stays 0.
REQ-033 P_READY=0; three good frames 0x01, 0x02, 0x03 -> OVERFLOW pulses once on the third frame; P_READY then high -> 0x01 and 0x02 are delivered in order, and 0x03 is never delivered.
REQ-034 Frame 0x3C sent with S_VALID low for 5 cycles between every pair of bits -> 0x3C is delivered; no error pulses.
REQ-035 New S_START after 4 bits of a frame, followed by a full 0x7E frame -> only 0x7E is delivered. Separately, R asserted after 4 bits, then the remaining bits sent without S_START -> no output.
